photon_gate_counter: RTL
========================

PHOTON_GATE_COUNTER -- requirements
Module: photon_gate_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 20_000_000, clk_20MHz cycles per counting window (1 s).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops on ex_pulse (legal range 2..3).
REQ-003 clk_20MHz  input  1  system clock, 20 MHz; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ex_pulse  input  1  asynchronous external photon pulse.
REQ-006 en  input  1  counting enable, level.
REQ-007 gate_tick  output  1  one-cycle strobe in the last cycle of each window.
REQ-008 result_bin  output  27  binary count of the last completed window.
REQ-009 result_bcd  output  32  8-digit packed BCD of result_bin; digit 0 in [3:0].
REQ-010 valid  output  1  result pending for the display adapter.
REQ-011 ack  input  1  display adapter consumed the result.
REQ-012 sat  output  1  last completed window saturated at 99_999_999.
REQ-013 overrun  output  1  sticky: a result was overwritten before ack.

Function
REQ-014 ex_pulse SHALL pass through SYNC_STAGES flops, then one edge-detect flop; a count event is one cycle where the synchronised value is 1 and the previous value is 0.
REQ-015 Pulses with high and low times >= 2 cycles (100 ns) SHALL each be counted exactly once; shorter pulses may be missed.
REQ-016 Gate counter SHALL run 0..GATE_CYCLES-1 while en=1; gate_tick=1 when it equals GATE_CYCLES-1, then it wraps to 0.
REQ-017 Accumulator SHALL increment per count event and saturate at 99_999_999 without wrapping.
REQ-018 On the gate_tick cycle, accumulator (+1 if an event occurs in that same cycle) SHALL load into a snapshot register; the accumulator restarts at 0 next cycle.
REQ-019 No event is lost or double-counted across a window boundary.
REQ-020 Converter FSM states: C_IDLE, C_SHIFT, C_LOAD.
- C_IDLE -> C_SHIFT on snapshot load.
- C_SHIFT: 27 iterations of shift-add-3 (double dabble), one bit per cycle.
- C_LOAD: register result_bin, result_bcd, sat, set valid=1 -> C_IDLE.
REQ-021 valid SHALL rise exactly 29 cycles after the gate_tick cycle (tick at T, valid first high at T+29).
REQ-022 GATE_CYCLES SHALL be >= 32 so a conversion always completes before the next snapshot.
REQ-023 valid SHALL stay high until a cycle with ack=1; it clears the following cycle; ack with valid=0 is ignored.
REQ-024 If C_LOAD coincides with ack, the new result wins: valid stays 1 and outputs take the new values.
REQ-025 If C_LOAD occurs while valid=1 and ack=0, outputs SHALL be overwritten and overrun set to 1.
REQ-026 overrun SHALL clear only on a cycle with ack=1 and valid=1 that does not coincide with another overrun.
REQ-027 result_bin/result_bcd/sat SHALL change only in C_LOAD.
REQ-028 en=0:
- gate counter and accumulator hold at 0;
- gate_tick=0;
- an in-progress conversion completes and presents normally.
REQ-029 en 0->1: a fresh full window of GATE_CYCLES cycles starts on the first cycle en=1.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear the following, and the FSM goes to C_IDLE:
- synchroniser and edge flops;
- gate counter, accumulator, snapshot;
- result_bin, result_bcd;
- valid, sat, overrun, gate_tick.
REQ-031 Reset mid-window or mid-conversion SHALL discard all partial data; no valid is produced for that window.

Verification
REQ-032 GATE_CYCLES=100, en=1, 7 pulses (4 cycles high, 4 low) -> gate_tick at cycle 99, valid at 128, result_bin=7, result_bcd=32'h00000007.
REQ-033 Pulse whose edge is detected exactly on the gate_tick cycle -> counted in the ending window (REQ-018); the next window excludes it; total over 3 windows equals pulses sent.
REQ-034 Force accumulator near limit (GATE_CYCLES=200, continuous 2-high/2-low pulses with counter preset to 99_999_990 by force) -> result_bin=99_999_999, result_bcd=32'h99999999, sat=1.
REQ-035 ack held 0 across two windows -> second C_LOAD overwrites, overrun=1, valid=1; ack=1 for one cycle -> valid=0 and overrun=0 next cycle.
REQ-036 rst_n pulsed low during C_SHIFT -> all outputs 0 immediately; no valid afterwards until a full new window completes.
REQ-037 en dropped mid-window for 50 cycles then raised -> no gate_tick while low; next gate_tick exactly 100 cycles after en rises; count covers only post-rise pulses.

Source files
------------

// File: rtl/photon_gate_counter.sv
// Gated photon counter: synchronises ex_pulse, counts rising edges over a fixed
// window, then converts the snapshot to packed BCD by serial double dabble.
module photon_gate_counter #(
    parameter int GATE_CYCLES = 20_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_20MHz,
    input  logic        rst_n,
    input  logic        ex_pulse,
    input  logic        en,
    input  logic        ack,
    output logic        gate_tick,
    output logic [26:0] result_bin,
    output logic [31:0] result_bcd,
    output logic        valid,
    output logic        sat,
    output logic        overrun
);

    localparam int              GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [26:0]     ACC_MAX   = 27'd99_999_999;
    localparam logic [4:0]      LAST_ITER = 5'd26;

    typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_LOAD} conv_state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   count_ev;

    logic [GW-1:0] gate_q, gate_d;
    logic [26:0]   acc_q, acc_d, acc_inc;
    logic          snap_load;

    conv_state_e   state_q, state_d;
    logic [26:0]   snap_q, snap_d;
    logic [26:0]   sh_bin_q, sh_bin_d;
    logic [31:0]   sh_bcd_q, sh_bcd_d;
    logic [4:0]    iter_q, iter_d;

    logic [26:0]   result_bin_q, result_bin_d;
    logic [31:0]   result_bcd_q, result_bcd_d;
    logic          valid_q, valid_d;
    logic          sat_q, sat_d;
    logic          overrun_q, overrun_d;

    // Adds 3 to every BCD digit >= 5 ahead of the double-dabble shift.
    function automatic logic [31:0] add3(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 8; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign count_ev  = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign gate_tick = en && (gate_q == GATE_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        gate_d    = gate_q;
        acc_d     = acc_q;
        snap_load = 1'b0;
        acc_inc   = (count_ev && acc_q != ACC_MAX) ? acc_q + 27'd1 : acc_q;
        if (!en) begin
            gate_d = '0;
            acc_d  = '0;
        end else if (gate_q == GATE_LAST) begin
            // An event landing on the tick cycle belongs to the window that is closing.
            gate_d    = '0;
            acc_d     = '0;
            snap_load = 1'b1;
        end else begin
            gate_d = gate_q + 1'b1;
            acc_d  = acc_inc;
        end
    end

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        sh_bin_d     = sh_bin_q;
        sh_bcd_d     = sh_bcd_q;
        iter_d       = iter_q;
        result_bin_d = result_bin_q;
        result_bcd_d = result_bcd_q;
        sat_d        = sat_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;

        if (ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            C_IDLE: begin
                if (snap_load) begin
                    snap_d   = acc_inc;
                    sh_bin_d = acc_inc;
                    sh_bcd_d = '0;
                    iter_d   = '0;
                    state_d  = C_SHIFT;
                end
            end
            C_SHIFT: begin
                {sh_bcd_d, sh_bin_d} = {add3(sh_bcd_q), sh_bin_q} << 1;
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST_ITER) state_d = C_LOAD;
            end
            C_LOAD: begin
                // A fresh result always wins over a coincident ack.
                result_bin_d = snap_q;
                result_bcd_d = sh_bcd_q;
                sat_d        = (snap_q == ACC_MAX);
                valid_d      = 1'b1;
                if (valid_q && !ack) overrun_d = 1'b1;
                state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_20MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            edge_q       <= 1'b0;
            gate_q       <= '0;
            acc_q        <= '0;
            state_q      <= C_IDLE;
            snap_q       <= '0;
            sh_bin_q     <= '0;
            sh_bcd_q     <= '0;
            iter_q       <= '0;
            result_bin_q <= '0;
            result_bcd_q <= '0;
            valid_q      <= 1'b0;
            sat_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], ex_pulse};
            edge_q       <= sync_q[SYNC_STAGES-1];
            gate_q       <= gate_d;
            acc_q        <= acc_d;
            state_q      <= state_d;
            snap_q       <= snap_d;
            sh_bin_q     <= sh_bin_d;
            sh_bcd_q     <= sh_bcd_d;
            iter_q       <= iter_d;
            result_bin_q <= result_bin_d;
            result_bcd_q <= result_bcd_d;
            valid_q      <= valid_d;
            sat_q        <= sat_d;
            overrun_q    <= overrun_d;
        end
    end

    assign result_bin = result_bin_q;
    assign result_bcd = result_bcd_q;
    assign valid      = valid_q;
    assign sat        = sat_q;
    assign overrun    = overrun_q;

endmodule
